period_meter: RTL

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/sync_edge.sv | 36 +++
 rtl/period_meter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared state encoding and default sizing for the period meter.
package period_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_STALL = 2'd3
   } state_t;

   localparam int          DEF_CNT_W   = 32;
   localparam int unsigned DEF_TIMEOUT = 100_000_000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history register; registered one-cycle rise/fall pulses
// that appear on the third clk edge after d is first sampled.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_hist;
   logic r_rise;
   logic r_fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_hist <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
         r_hist <= r_sync;
         r_rise <= r_sync & ~r_hist;
         r_fall <= ~r_sync & r_hist;
      end
   end

   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: rtl/period_meter.sv
// Measures high/low half-periods of a slow asynchronous square wave in clk cycles,
// publishing a full period after each complete low phase and flagging stalls.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int          CNT_W   = DEF_CNT_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             clear,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             locked,
   output logic             stalled
);

   localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

   logic             w_rise;
   logic             w_fall;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_timeout;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] r_high_cnt;
   logic [CNT_W-1:0] r_low_cnt;
   logic [CNT_W-1:0] r_period;
   logic             r_upd;
   logic             r_valid;
   logic             r_locked;
   logic             r_stalled;

   sync_edge u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (sig_in),
      .rise (w_rise),
      .fall (w_fall)
   );

   // Stall fires on the cycle the counter would reach TIMEOUT; a tick in the same cycle wins.
   assign w_cnt_inc = r_cnt + LP_ONE;
   assign w_timeout = (w_cnt_inc == LP_TIMEOUT);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_high     <= '0;
         r_high_cnt <= '0;
         r_low_cnt  <= '0;
         r_period   <= '0;
         r_upd      <= 1'b0;
         r_valid    <= 1'b0;
         r_locked   <= 1'b0;
         r_stalled  <= 1'b0;
      end else begin
         r_upd   <= 1'b0;
         r_valid <= r_upd;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_state <= ST_HIGH;
                  r_cnt   <= LP_ONE;
               end
            end
            ST_HIGH: begin
               if (w_fall) begin
                  r_high  <= r_cnt;
                  r_cnt   <= LP_ONE;
                  r_state <= ST_LOW;
               end else if (w_timeout) begin
                  r_state   <= ST_STALL;
                  r_stalled <= 1'b1;
                  r_locked  <= 1'b0;
                  r_cnt     <= LP_TIMEOUT;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_LOW: begin
               if (w_rise) begin
                  r_high_cnt <= r_high;
                  r_low_cnt  <= r_cnt;
                  r_period   <= r_high + r_cnt;
                  r_upd      <= 1'b1;
                  r_locked   <= 1'b1;
                  r_cnt      <= LP_ONE;
                  r_state    <= ST_HIGH;
               end else if (w_timeout) begin
                  r_state   <= ST_STALL;
                  r_stalled <= 1'b1;
                  r_locked  <= 1'b0;
                  r_cnt     <= LP_TIMEOUT;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_STALL: begin
               if (w_rise) begin
                  r_state   <= ST_HIGH;
                  r_stalled <= 1'b0;
                  r_cnt     <= LP_ONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rise_tick = w_rise;
   assign fall_tick = w_fall;
   assign high_cnt  = r_high_cnt;
   assign low_cnt   = r_low_cnt;
   assign period    = r_period;
   assign valid     = r_valid;
   assign locked    = r_locked;
   assign stalled   = r_stalled;

endmodule
